// File: rtl/risc_v_alu_mc.sv
// Multi-cycle RISC-V execute ALU with registered results, valid/ready on both
// sides, and an optional bit-serial MUL/DIVU/REMU unit.
module risc_v_alu_mc #(
  parameter int unsigned XLEN   = 64,
  parameter bit          MDU_EN = 1'b1
) (
  input  logic            sys_clk,
  input  logic            sys_rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_ctl,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_out,
  output logic            zero,
  output logic            err
);

  localparam int unsigned SHW = $clog2(XLEN);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLL  = 4'b0011;
  localparam logic [3:0] OP_SRL  = 4'b0100;
  localparam logic [3:0] OP_SRA  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1000;
  localparam logic [3:0] OP_XOR  = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1010;
  localparam logic [3:0] OP_DIVU = 4'b1011;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_REMU = 4'b1101;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  state_e          state_q, state_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] alu_out_q, alu_out_d;
  logic            zero_q, zero_d;
  logic            err_q, err_d;
  logic [SHW-1:0]  cnt_q, cnt_d;
  logic [3:0]      op_q, op_d;
  logic [XLEN:0]   acc_q, acc_d;   // MUL: running product, DIV: partial remainder
  logic [XLEN-1:0] opa_q, opa_d;   // MUL: shifting multiplicand, DIV: dividend/quotient
  logic [XLEN-1:0] opb_q, opb_d;   // MUL: shifting multiplier, DIV: divisor

  logic [XLEN-1:0] simple_res;
  logic            undef_op;
  logic            is_mdu;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] mul_sum;
  logic [XLEN:0]   rem_sh;
  logic [XLEN:0]   acc_nx;
  logic [XLEN-1:0] opa_nx;
  logic [XLEN-1:0] opb_nx;
  logic [XLEN-1:0] mdu_res;

  assign shamt = b[SHW-1:0];

  // Single-cycle operation decode and result
  always_comb begin
    simple_res = '0;
    undef_op   = 1'b0;
    is_mdu     = 1'b0;
    case (alu_ctl)
      OP_AND:  simple_res = a & b;
      OP_OR:   simple_res = a | b;
      OP_ADD:  simple_res = a + b;
      OP_SUB:  simple_res = a - b;
      OP_SLT:  simple_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: simple_res = {{(XLEN-1){1'b0}}, (a < b)};
      OP_NOR:  simple_res = ~(a | b);
      OP_XOR:  simple_res = a ^ b;
      OP_SLL:  simple_res = a << shamt;
      OP_SRL:  simple_res = a >> shamt;
      OP_SRA:  simple_res = $signed(a) >>> shamt;
      OP_MUL, OP_DIVU, OP_REMU: begin
        if (MDU_EN) is_mdu   = 1'b1;
        else        undef_op = 1'b1;
      end
      default: undef_op = 1'b1;
    endcase
  end

  // One shift-add multiply step or one restoring-divide step
  always_comb begin
    mul_sum = acc_q[XLEN-1:0] + (opb_q[0] ? opa_q : '0);
    rem_sh  = {acc_q[XLEN-1:0], opa_q[XLEN-1]};
    acc_nx  = acc_q;
    opa_nx  = opa_q;
    opb_nx  = opb_q;
    mdu_res = '0;
    if (op_q == OP_MUL) begin
      acc_nx  = {1'b0, mul_sum};
      opa_nx  = opa_q << 1;
      opb_nx  = opb_q >> 1;
      mdu_res = mul_sum;
    end else begin
      if (rem_sh >= {1'b0, opb_q}) begin
        acc_nx = rem_sh - {1'b0, opb_q};
        opa_nx = {opa_q[XLEN-2:0], 1'b1};
      end else begin
        acc_nx = rem_sh;
        opa_nx = {opa_q[XLEN-2:0], 1'b0};
      end
      mdu_res = (op_q == OP_DIVU) ? opa_nx : acc_nx[XLEN-1:0];
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    alu_out_d   = alu_out_q;
    zero_d      = zero_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    acc_d       = acc_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d = alu_ctl;
          if (is_mdu) begin
            state_d = S_BUSY;
            cnt_d   = '0;
            acc_d   = '0;
            opa_d   = a;
            opb_d   = b;
          end else begin
            state_d     = S_DONE;
            out_valid_d = 1'b1;
            alu_out_d   = undef_op ? '0 : simple_res;
            zero_d      = undef_op ? 1'b1 : (simple_res == '0);
            err_d       = undef_op;
          end
        end
      end
      S_BUSY: begin
        acc_d = acc_nx;
        opa_d = opa_nx;
        opb_d = opb_nx;
        cnt_d = cnt_q + SHW'(1);
        if (cnt_q == SHW'(XLEN - 1)) begin
          state_d     = S_DONE;
          cnt_d       = '0;
          out_valid_d = 1'b1;
          alu_out_d   = mdu_res;
          zero_d      = (mdu_res == '0);
          err_d       = 1'b0;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    in_ready_d = (state_d == S_IDLE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      alu_out_q   <= '0;
      zero_q      <= 1'b1;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      op_q        <= '0;
      acc_q       <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      alu_out_q   <= alu_out_d;
      zero_q      <= zero_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      acc_q       <= acc_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign alu_out   = alu_out_q;
  assign zero      = zero_q;
  assign err       = err_q;

endmodule
